// File: rtl/mmio_responder_pkg.sv
// Shared processor package: bus width, MMIO device map, opcodes and
// the active-low seven-segment glyph table used by the board I/O block.
package mmio_responder_pkg;

  localparam int MMIO_DBITS = 32;

  localparam logic [31:0] MMIO_ADDR_HEX  = 32'hF000_0000;
  localparam logic [31:0] MMIO_ADDR_LEDR = 32'hF000_0004;
  localparam logic [31:0] MMIO_ADDR_LEDG = 32'hF000_0008;
  localparam logic [31:0] MMIO_ADDR_KEY  = 32'hF000_0010;
  localparam logic [31:0] MMIO_ADDR_SW   = 32'hF000_0014;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    DEV_NONE,
    DEV_HEX,
    DEV_LEDR,
    DEV_LEDG,
    DEV_KEY,
    DEV_SW
  } devSel_e;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] segPattern(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Hex nibble to active-low seven-segment drive.
module sevenseg_decoder
  import mmio_responder_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segments
);

  assign segments = segPattern(digit);

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped board I/O: HEX/LED output registers plus debounced KEY/SW
// inputs with press-sticky bits, answered with zero-cycle load latency.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int               DBITS           = MMIO_DBITS,
  parameter logic [DBITS-1:0] ADDR_HEX        = DBITS'(MMIO_ADDR_HEX),
  parameter logic [DBITS-1:0] ADDR_LEDR       = DBITS'(MMIO_ADDR_LEDR),
  parameter logic [DBITS-1:0] ADDR_LEDG       = DBITS'(MMIO_ADDR_LEDG),
  parameter logic [DBITS-1:0] ADDR_KEY        = DBITS'(MMIO_ADDR_KEY),
  parameter logic [DBITS-1:0] ADDR_SW         = DBITS'(MMIO_ADDR_SW),
  parameter logic [15:0]      DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DBITS-1:0] addr,
  input  logic [DBITS-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [DBITS-1:0] rdata,
  output logic             hit,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG
);

  localparam int              NIN     = 14;
  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 16'd1);
  // KEY lives in bits [3:0] and idles released (high); SW in bits [13:4].
  localparam logic [NIN-1:0]  ACC_RST = {10'h000, 4'hF};

  devSel_e          devSel;
  logic [15:0]      hexReg;
  logic [9:0]       ledrReg;
  logic [7:0]       ledgReg;
  logic [3:0]       stickyReg;
  logic [3:0]       stickyNext;
  logic [3:0]       pressed;
  logic [3:0]       keyPressSet;
  logic             clearKey;
  logic [NIN-1:0]   sync1Reg;
  logic [NIN-1:0]   syncReg;
  logic [NIN-1:0]   acceptedReg;
  logic [NIN-1:0]   acceptedNext;
  logic [NIN-1:0]   differs;
  logic [NIN-1:0]   acceptStrobe;
  logic [CNT_W-1:0] cntReg  [NIN];
  logic [CNT_W-1:0] cntNext [NIN];
  logic [6:0]       hexSeg  [4];
  logic [DBITS-1:0] readData;
  logic             unusedBits;

  always_comb begin
    devSel = DEV_NONE;
    if (addr == ADDR_HEX)       devSel = DEV_HEX;
    else if (addr == ADDR_LEDR) devSel = DEV_LEDR;
    else if (addr == ADDR_LEDG) devSel = DEV_LEDG;
    else if (addr == ADDR_KEY)  devSel = DEV_KEY;
    else if (addr == ADDR_SW)   devSel = DEV_SW;
  end

  assign hit      = (devSel != DEV_NONE);
  assign clearKey = we && (devSel == DEV_KEY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hexReg  <= '0;
      ledrReg <= '0;
      ledgReg <= '0;
    end else if (we) begin
      if (devSel == DEV_HEX)  hexReg  <= wdata[15:0];
      if (devSel == DEV_LEDR) ledrReg <= wdata[9:0];
      if (devSel == DEV_LEDG) ledgReg <= wdata[7:0];
    end
  end

  // Counter only runs while the synchronized input disagrees with the
  // accepted value, so any bounce shorter than DEBOUNCE_CYCLES is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : gDebounce
      assign differs[gi]      = syncReg[gi] != acceptedReg[gi];
      assign acceptStrobe[gi] = differs[gi] && (cntReg[gi] == CNT_MAX);
      assign cntNext[gi]      = (!differs[gi] || acceptStrobe[gi]) ? '0
                                : cntReg[gi] + CNT_W'(1);
      assign acceptedNext[gi] = acceptStrobe[gi] ? syncReg[gi] : acceptedReg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1Reg    <= '0;
      syncReg     <= '0;
      acceptedReg <= ACC_RST;
      for (int i = 0; i < NIN; i++) cntReg[i] <= '0;
    end else begin
      sync1Reg    <= {SW, KEY};
      syncReg     <= sync1Reg;
      acceptedReg <= acceptedNext;
      for (int i = 0; i < NIN; i++) cntReg[i] <= cntNext[i];
    end
  end

  // A press is accepted on the same edge that the sticky bit is set.
  assign pressed     = ~acceptedReg[3:0];
  assign keyPressSet = acceptStrobe[3:0] & acceptedReg[3:0];
  assign stickyNext  = (stickyReg & ~{4{clearKey}}) | keyPressSet;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stickyReg <= '0;
    else          stickyReg <= stickyNext;
  end

  always_comb begin
    readData = '0;
    if (re) begin
      case (devSel)
        DEV_HEX:  readData = DBITS'(hexReg);
        DEV_LEDR: readData = DBITS'(ledrReg);
        DEV_LEDG: readData = DBITS'(ledgReg);
        DEV_KEY:  readData = DBITS'({stickyReg, pressed});
        DEV_SW:   readData = DBITS'(acceptedReg[13:4]);
        default:  readData = '0;
      endcase
    end
  end

  assign rdata = readData;
  assign LEDR  = ledrReg;
  assign LEDG  = ledgReg;

  generate
    for (gi = 0; gi < 4; gi++) begin : gHex
      sevenseg_decoder uDigit (
        .digit    (hexReg[gi*4 +: 4]),
        .segments (hexSeg[gi])
      );
    end
  endgenerate

  assign HEX0 = hexSeg[0];
  assign HEX1 = hexSeg[1];
  assign HEX2 = hexSeg[2];
  assign HEX3 = hexSeg[3];

  assign unusedBits = ^{wdata[DBITS-1:16], acceptStrobe[NIN-1:4]};

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: bus vector table plus debounce,
// sticky-key and asynchronous-reset sequences.
module tb_mmio_responder;

  localparam logic [31:0] A_HEX  = 32'hF000_0000;
  localparam logic [31:0] A_LEDR = 32'hF000_0004;
  localparam logic [31:0] A_LEDG = 32'hF000_0008;
  localparam logic [31:0] A_KEY  = 32'hF000_0010;
  localparam logic [31:0] A_SW   = 32'hF000_0014;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic [31:0] rdata;
  logic        hit;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;

  int tests    = 0;
  int failures = 0;

  mmio_responder #(.DEBOUNCE_CYCLES(16'd4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .re      (re),
    .rdata   (rdata),
    .hit     (hit),
    .KEY     (KEY),
    .SW      (SW),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .LEDR    (LEDR),
    .LEDG    (LEDG)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        expHit;
    logic [31:0] expRdata;
    logic [15:0] expHex;
    logic [9:0]  expLedr;
    logic [7:0]  expLedg;
  } vec_t;

  vec_t vecs [16];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    addr  = a;
    wdata = d;
    we    = w;
    re    = r;
  endtask

  task automatic checkOutputs(input string tag, input logic [15:0] h,
                              input logic [9:0] lr, input logic [7:0] lg);
    check({tag, "_hex0"}, 32'(HEX0), 32'(seg7(h[3:0])));
    check({tag, "_hex1"}, 32'(HEX1), 32'(seg7(h[7:4])));
    check({tag, "_hex2"}, 32'(HEX2), 32'(seg7(h[11:8])));
    check({tag, "_hex3"}, 32'(HEX3), 32'(seg7(h[15:12])));
    check({tag, "_ledr"}, 32'(LEDR), 32'(lr));
    check({tag, "_ledg"}, 32'(LEDG), 32'(lg));
  endtask

  initial begin
    // Expected HEX/LED columns are the state before this vector's edge.
    vecs[0]  = '{A_HEX,         32'h0,        0, 1, 1, 32'h0,    16'h0000, 10'h000, 8'h00};
    vecs[1]  = '{A_HEX,         32'hABCD1234, 1, 1, 1, 32'h0,    16'h0000, 10'h000, 8'h00};
    vecs[2]  = '{A_HEX,         32'h0,        0, 1, 1, 32'h1234, 16'h1234, 10'h000, 8'h00};
    vecs[3]  = '{A_LEDR,        32'hFFFFFFFF, 1, 0, 1, 32'h0,    16'h1234, 10'h000, 8'h00};
    vecs[4]  = '{A_LEDG,        32'hFFFFFFFF, 1, 0, 1, 32'h0,    16'h1234, 10'h3FF, 8'h00};
    vecs[5]  = '{A_LEDR,        32'h0,        0, 1, 1, 32'h3FF,  16'h1234, 10'h3FF, 8'hFF};
    vecs[6]  = '{A_LEDG,        32'h0,        0, 1, 1, 32'hFF,   16'h1234, 10'h3FF, 8'hFF};
    vecs[7]  = '{32'hF000000C,  32'h00000000, 1, 1, 0, 32'h0,    16'h1234, 10'h3FF, 8'hFF};
    vecs[8]  = '{A_LEDR,        32'h0,        0, 1, 1, 32'h3FF,  16'h1234, 10'h3FF, 8'hFF};
    vecs[9]  = '{A_HEX,         32'h0,        0, 1, 1, 32'h1234, 16'h1234, 10'h3FF, 8'hFF};
    vecs[10] = '{A_SW,          32'h0000DEAD, 1, 0, 1, 32'h0,    16'h1234, 10'h3FF, 8'hFF};
    vecs[11] = '{A_SW,          32'h0,        0, 1, 1, 32'h0,    16'h1234, 10'h3FF, 8'hFF};
    vecs[12] = '{A_KEY,         32'h0,        0, 1, 1, 32'h0,    16'h1234, 10'h3FF, 8'hFF};
    vecs[13] = '{A_HEX,         32'h0,        0, 0, 1, 32'h0,    16'h1234, 10'h3FF, 8'hFF};
    vecs[14] = '{32'hF0000018,  32'h0,        0, 1, 0, 32'h0,    16'h1234, 10'h3FF, 8'hFF};
    vecs[15] = '{32'hF0000001,  32'h0,        0, 1, 0, 32'h0,    16'h1234, 10'h3FF, 8'hFF};

    reset_n = 1'b0;
    KEY     = 4'hF;
    SW      = 10'h000;
    bus(A_HEX, 32'h0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    check("reset_hit", 32'(hit), 32'h1);
    check("reset_rdata", rdata, 32'h0);
    checkOutputs("reset", 16'h0000, 10'h000, 8'h00);

    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      bus(vecs[v].addr, vecs[v].wdata, vecs[v].we, vecs[v].re);
      #1;
      $display("[TB] vec %0d addr=%h wdata=%h we=%b re=%b hit=%b rdata=%h",
               v, addr, wdata, we, re, hit, rdata);
      check($sformatf("vec%0d_hit", v), 32'(hit), 32'(vecs[v].expHit));
      check($sformatf("vec%0d_rdata", v), rdata, vecs[v].expRdata);
      checkOutputs($sformatf("vec%0d", v), vecs[v].expHex, vecs[v].expLedr, vecs[v].expLedg);
    end
    @(negedge clk);
    bus(A_SW, 32'h0, 1'b0, 1'b1);

    // SW: 2-cycle glitch must be filtered, then 6 edges to accept 0x155.
    SW = 10'h155;
    repeat (2) @(negedge clk);
    SW = 10'h000;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("sw_glitch_k%0d", k), rdata, 32'h0);
    end
    SW = 10'h155;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      $display("[TB] sw settle edge %0d rdata=%h", k, rdata);
      check($sformatf("sw_settle_k%0d", k), rdata, (k >= 6) ? 32'h155 : 32'h0);
    end

    // KEY[2] press, release, then clear stickies by store.
    bus(A_KEY, 32'h0, 1'b0, 1'b1);
    KEY = 4'b1011;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("key_press_k%0d", k), rdata, (k >= 6) ? 32'h44 : 32'h0);
    end
    KEY = 4'hF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("key_release_k%0d", k), rdata, (k >= 6) ? 32'h40 : 32'h44);
    end
    we = 1'b1;
    #1;
    check("key_clear_pre_edge", rdata, 32'h40);
    @(negedge clk);
    we = 1'b0;
    #1;
    $display("[TB] key clear rdata=%h", rdata);
    check("key_clear", rdata, 32'h0);

    // KEY[0] press accepted on the same edge as a sticky clear: set wins.
    KEY = 4'b1110;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("key0_press_k%0d", k), rdata, 32'h0);
    end
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    #1;
    $display("[TB] set/clear collision rdata=%h", rdata);
    check("key_set_wins", rdata, 32'h11);
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    #1;
    check("key_clear_held", rdata, 32'h01);

    // Asynchronous reset mid-debounce, with LEDs and HEX still loaded.
    KEY = 4'hF;
    bus(A_SW, 32'h0, 1'b0, 1'b1);
    SW = 10'h2AA;
    repeat (3) @(negedge clk);
    checkOutputs("pre_reset", 16'h1234, 10'h3FF, 8'hFF);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    $display("[TB] async reset asserted rdata=%h", rdata);
    checkOutputs("async_reset", 16'h0000, 10'h000, 8'h00);
    check("async_reset_sw", rdata, 32'h0);
    addr = A_KEY;
    #1;
    check("async_reset_key", rdata, 32'h0);
    addr = A_SW;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("sw_after_reset_k%0d", k), rdata, (k >= 6) ? 32'h2AA : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
